// File: rtl/led_sreg_pwm_driver.sv
// led_sreg_pwm_driver: drives CHAINS parallel 74HC595-style LED shift registers with
// per-LED PWM brightness. Optional per-LED blink is compiled in with LED_SREG_BLINK_EN.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_LOAD     | snapshot inputs, compute on-bits, start at bit COUNT-1
// S_SHIFT_LO | sreg_clk low, current bit presented on sreg_d
// S_SHIFT_HI | sreg_clk high (registers clock on this rising edge)
// S_LATCH_HI | sreg_ld high, frame_done pulses for one clk
// S_LATCH_LO | sreg_ld low, advance PWM (and blink) frame counters
module led_sreg_pwm_driver #(
  parameter int COUNT     = 16,
  parameter int CHAINS    = 1,
  parameter int PWM_BITS  = 4,
  parameter int INVERT    = 0,
  parameter int PRESCALE  = 63,
  parameter int BLINK_DIV = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [CHAINS*COUNT*PWM_BITS-1:0]    led_level,
  input  logic [CHAINS*COUNT-1:0]             led_blink,
  output logic [CHAINS-1:0]                   sreg_d,
  output logic                                sreg_ld,
  output logic                                sreg_clk,
  output logic                                frame_done
);

  localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [PW-1:0]       PRE_LAST = PW'(PRESCALE);
  localparam logic [IW-1:0]       IDX_TOP  = IW'(COUNT - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic                INV      = (INVERT != 0);

  typedef enum logic [2:0] {S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_LATCH_HI, S_LATCH_LO} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         pre_q;
  logic                  tick;
  logic [IW-1:0]         idx_q, idx_d;
  logic [COUNT-1:0]      on_q [CHAINS];
  logic [COUNT-1:0]      on_d [CHAINS];
  logic [COUNT-1:0]      on_now [CHAINS];
  logic [PWM_BITS-1:0]   pwm_q, pwm_d;
  logic [CHAINS-1:0]     sd_q, sd_d;
  logic                  ld_q, ld_d, sck_q, sck_d, fd_q, fd_d;
  logic [CHAINS*COUNT-1:0] blink_mask;

  assign tick = (pre_q == PRE_LAST);

  // Prescaler: one tick every PRESCALE+1 cycles paces every sreg phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + PW'(1);
  end

`ifdef LED_SREG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  logic [BW-1:0] blink_frame_q;
  logic          blink_phase_q;

  // Blink half-period counter; phase starts at 0 so blinking LEDs are visible first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_frame_q <= '0;
      blink_phase_q <= 1'b0;
    end else if (tick && state_q == S_LATCH_LO) begin
      if (blink_frame_q == BLINK_LAST) begin
        blink_frame_q <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_frame_q <= blink_frame_q + BW'(1);
      end
    end
  end

  assign blink_mask = led_blink & {(CHAINS*COUNT){blink_phase_q}};
`else
  logic unused_blink;
  assign unused_blink = ^{led_blink, BLINK_DIV[0]};
  assign blink_mask   = '0;
`endif

  // Per-LED on decision for the frame about to be loaded.
  always_comb begin
    for (int c = 0; c < CHAINS; c++) begin
      on_now[c] = '0;
      for (int i = 0; i < COUNT; i++) begin
        on_now[c][i] = (led_level[(c*COUNT+i)*PWM_BITS +: PWM_BITS] > pwm_q) &&
                       !blink_mask[c*COUNT+i];
      end
    end
  end

  // Next-state and next-output logic; everything moves only on tick.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    on_d    = on_q;
    pwm_d   = pwm_q;
    sd_d    = sd_q;
    ld_d    = ld_q;
    sck_d   = sck_q;
    fd_d    = 1'b0;
    if (tick) begin
      case (state_q)
        S_LOAD: begin
          on_d    = on_now;
          idx_d   = IDX_TOP;
          sck_d   = 1'b0;
          for (int c = 0; c < CHAINS; c++) sd_d[c] = on_now[c][IDX_TOP] ^ INV;
          state_d = S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          sck_d   = 1'b1;
          state_d = S_SHIFT_HI;
        end
        S_SHIFT_HI: begin
          sck_d = 1'b0;
          if (idx_q == '0) begin
            ld_d    = 1'b1;
            fd_d    = 1'b1;
            state_d = S_LATCH_HI;
          end else begin
            idx_d   = idx_q - IW'(1);
            for (int c = 0; c < CHAINS; c++) sd_d[c] = on_q[c][idx_q - IW'(1)] ^ INV;
            state_d = S_SHIFT_LO;
          end
        end
        S_LATCH_HI: begin
          ld_d    = 1'b0;
          state_d = S_LATCH_LO;
        end
        S_LATCH_LO: begin
          pwm_d   = (pwm_q == PWM_LAST) ? '0 : pwm_q + PWM_BITS'(1);
          state_d = S_LOAD;
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      idx_q   <= '0;
      for (int c = 0; c < CHAINS; c++) on_q[c] <= '0;
      pwm_q   <= '0;
      sd_q    <= '0;
      ld_q    <= 1'b0;
      sck_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      on_q    <= on_d;
      pwm_q   <= pwm_d;
      sd_q    <= sd_d;
      ld_q    <= ld_d;
      sck_q   <= sck_d;
      fd_q    <= fd_d;
    end
  end

  assign sreg_d     = sd_q;
  assign sreg_ld    = ld_q;
  assign sreg_clk   = sck_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_led_sreg_pwm_driver.sv
// Directed bench for led_sreg_pwm_driver: two COUNT=4/CHAINS=2 instances (normal and
// inverted) plus a COUNT=4 PWM_BITS=2 instance exercising PWM and, if enabled, blink.
module tb_led_sreg_pwm_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] lvl0, lvl1, blk0, blk1, lvl2;
  logic [3:0] blk2;
  logic [1:0] d0, d1;
  logic [0:0] d2;
  logic ld0, sck0, fd0, ld1, sck1, fd1, ld2, sck2, fd2;

  led_sreg_pwm_driver #(.COUNT(4), .CHAINS(2), .PWM_BITS(1), .INVERT(0), .PRESCALE(1), .BLINK_DIV(2))
    u0 (.clk(clk), .rst_n(rst_n), .led_level(lvl0), .led_blink(blk0),
        .sreg_d(d0), .sreg_ld(ld0), .sreg_clk(sck0), .frame_done(fd0));
  led_sreg_pwm_driver #(.COUNT(4), .CHAINS(2), .PWM_BITS(1), .INVERT(1), .PRESCALE(1), .BLINK_DIV(2))
    u1 (.clk(clk), .rst_n(rst_n), .led_level(lvl1), .led_blink(blk1),
        .sreg_d(d1), .sreg_ld(ld1), .sreg_clk(sck1), .frame_done(fd1));
  led_sreg_pwm_driver #(.COUNT(4), .CHAINS(1), .PWM_BITS(2), .INVERT(0), .PRESCALE(0), .BLINK_DIV(2))
    u2 (.clk(clk), .rst_n(rst_n), .led_level(lvl2), .led_blink(blk2),
        .sreg_d(d2), .sreg_ld(ld2), .sreg_clk(sck2), .frame_done(fd2));

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Frame capture: bits sampled when sreg_clk rises, frame closed when sreg_ld rises.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [3:0] q2[$];
  int qn0[$];
  int qfd[$];
  int qldw[$];
  int qfdw[$];
  logic [3:0] sh0a, sh0b, sh1a, sh1b, sh2;
  int nb0 = 0, ldw0 = 0, fdw0 = 0;
  logic sck0_p = 0, ld0_p = 0, fd0_p = 0, sck1_p = 0, ld1_p = 0, sck2_p = 0, ld2_p = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sh0a = '0; sh0b = '0; sh1a = '0; sh1b = '0; sh2 = '0;
      nb0 = 0; ldw0 = 0; fdw0 = 0;
    end else begin
      if (sck0 && !sck0_p) begin
        sh0a = {sh0a[2:0], d0[0]}; sh0b = {sh0b[2:0], d0[1]}; nb0++;
      end
      if (ld0 && !ld0_p) begin
        q0.push_back({sh0b, sh0a}); qn0.push_back(nb0); nb0 = 0;
      end
      if (ld0) ldw0++;
      else if (ld0_p) begin qldw.push_back(ldw0); ldw0 = 0; end
      if (fd0 && !fd0_p) qfd.push_back(cyc);
      if (fd0) fdw0++;
      else if (fd0_p) begin qfdw.push_back(fdw0); fdw0 = 0; end
      if (sck1 && !sck1_p) begin sh1a = {sh1a[2:0], d1[0]}; sh1b = {sh1b[2:0], d1[1]}; end
      if (ld1 && !ld1_p) q1.push_back({sh1b, sh1a});
      if (sck2 && !sck2_p) sh2 = {sh2[2:0], d2[0]};
      if (ld2 && !ld2_p) q2.push_back(sh2);
    end
    sck0_p = sck0; ld0_p = ld0; fd0_p = fd0;
    sck1_p = sck1; ld1_p = ld1; sck2_p = sck2; ld2_p = ld2;
  end

  // Expected u2 frame: idx3=2, idx2=0, idx1=3, idx0=2 with blink.
  function automatic logic [3:0] exp2(input int f);
    int p;
    logic on2, ph;
    p   = f % 3;
    on2 = (2 > p);
`ifdef LED_SREG_BLINK_EN
    ph  = ((f / 2) % 2) == 1;
`else
    ph  = 1'b0;
`endif
    return {on2, 1'b0, 1'b1, on2 && !ph};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, n, nfd;
    lvl0 = 8'hFB; lvl1 = 8'hFB; blk0 = '0; blk1 = '0;
    lvl2 = 8'h8E; blk2 = 4'b0001;

    repeat (4) begin
      @(negedge clk); #1;
      chk("rst_hold_u0", {27'd0, d0, ld0, sck0, fd0}, 0);
      chk("rst_hold_u2", {28'd0, d2, ld2, sck2, fd2}, 0);
    end
    rst_n = 1'b1;
    rel = cyc;

    for (int k = 0; k < 400 && !(q0.size() >= 3 && q1.size() >= 2 && q2.size() >= 6); k++) begin
      @(negedge clk); #1;
    end
    if (!(q0.size() >= 3 && q1.size() >= 2 && q2.size() >= 6)) chk("timeout_frames", 0, 1);
    else begin
      for (int i = 0; i < 3; i++) chk("u0_frame", q0[i], 8'hFB);
      chk("u0_bits", qn0[0], 4);
      for (int i = 0; i < 2; i++) chk("u1_inv_frame", q1[i], 8'h04);
      chk("first_fd_lat", qfd[0] - rel, 18);
      chk("period0", qfd[1] - qfd[0], 22);
      chk("period1", qfd[2] - qfd[1], 22);
      chk("ld_width", qldw[0], 2);
      chk("fd_width", qfdw[0], 1);
      for (int i = 0; i < 6; i++) chk("u2_pwm_frame", q2[i], exp2(i));
    end

    for (int k = 0; k < 200 && !(nb0 == 2 && sck0); k++) begin
      @(negedge clk); #1;
    end
    if (!(nb0 == 2 && sck0)) chk("timeout_bit2", 0, 1);
    lvl0 = 8'h36;
    n = q0.size();
    for (int k = 0; k < 200 && q0.size() < n + 2; k++) begin
      @(negedge clk); #1;
    end
    if (q0.size() < n + 2) chk("timeout_lvlchg", 0, 1);
    else begin
      chk("lvlchg_cur", q0[n], 8'hFB);
      chk("lvlchg_next", q0[n+1], 8'h36);
    end

    for (int k = 0; k < 200 && !(sck0 && nb0 >= 1); k++) begin
      @(negedge clk); #1;
    end
    if (!(sck0 && nb0 >= 1)) chk("timeout_midframe", 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_u0", {27'd0, d0, ld0, sck0, fd0}, 0);
    chk("async_rst_u2", {28'd0, d2, ld2, sck2, fd2}, 0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    rel = cyc;
    n = q0.size();
    nfd = qfd.size();
    for (int k = 0; k < 200 && q0.size() < n + 1; k++) begin
      @(negedge clk); #1;
    end
    if (q0.size() < n + 1) chk("timeout_restart", 0, 1);
    else begin
      chk("restart_frame", q0[n], 8'h36);
      chk("restart_bits", qn0[n], 4);
      chk("restart_fd_lat", qfd[nfd] - rel, 18);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
